// File: rtl/rotor_stepper.sv
// ---------------------------------------------------------------------------
// rotor_stepper
//
// Holds the left/middle/right rotor positions of an Enigma-style machine and
// advances them once per accepted keypress. It follows the historical stepping
// rule, including the middle-rotor double-step. The stepped positions are
// presented to the downstream encode stages through a valid/ready handshake.
// They stay frozen until the encode path takes them.
//
// Parameters
//   RESET_POS    position (0..25) loaded into all three rotors on reset
//   DOUBLE_STEP  1 = middle rotor also steps when it sits on its own notch
//                0 = plain odometer carry
//
// Ports
//   clk                  system clock, rising edge
//   reset                synchronous, active-high
//   load                 load start positions from load_* (accepted in IDLE only)
//   load_left/middle/right  start positions; values 26..31 are folded to 0..5
//   type_left/middle/right  rotor type 0..7 = I..VIII
//   key_valid/key_ready  keypress handshake
//   pos_valid/pos_ready  stepped-position handshake towards the encode path
//   rotor_left/middle/right current positions, always 0..25
//   key_count            (KEY_COUNT_EN only) accepted keypresses, wraps at 16 bits
//
// Build option
//   KEY_COUNT_EN  when defined, adds the key_count output and its counter.
//
// FSM states
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | waiting for a keypress; load is accepted here
//   STEP    | one cycle: register the stepped positions
//   HOLD    | positions valid and frozen until pos_ready
// ---------------------------------------------------------------------------
module rotor_stepper #(
    parameter int unsigned RESET_POS   = 0,
    parameter bit          DOUBLE_STEP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [4:0]  load_left,
    input  logic [4:0]  load_middle,
    input  logic [4:0]  load_right,
    input  logic [2:0]  type_left,
    input  logic [2:0]  type_middle,
    input  logic [2:0]  type_right,
    input  logic        key_valid,
    output logic        key_ready,
    output logic        pos_valid,
    input  logic        pos_ready,
    output logic [4:0]  rotor_left,
    output logic [4:0]  rotor_middle,
    output logic [4:0]  rotor_right
`ifdef KEY_COUNT_EN
    ,
    output logic [15:0] key_count
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_STEP = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [4:0] RESET_POS_5 = 5'(RESET_POS % 26);

    logic [1:0] state;
    logic       key_accept;
    logic       right_notch;
    logic       middle_notch;
    logic       middle_step;
    logic       left_step;

    // The left rotor has nothing further left to carry into, so its type
    // never affects stepping.
    logic       unused_type_left;
    assign unused_type_left = ^type_left;

    // Fold out-of-range load values back into 0..25.
    function automatic logic [4:0] fold26(input logic [4:0] v);
        return (v >= 5'd26) ? (v - 5'd26) : v;
    endfunction

    function automatic logic [4:0] inc26(input logic [4:0] v);
        return (v == 5'd25) ? 5'd0 : (v + 5'd1);
    endfunction

    // Notch position per rotor type. VI..VIII carry at both Z and M.
    function automatic logic on_notch(input logic [2:0] rotor_type,
                                      input logic [4:0] pos);
        logic hit;
        case (rotor_type)
            3'd0:    hit = (pos == 5'd16);
            3'd1:    hit = (pos == 5'd4);
            3'd2:    hit = (pos == 5'd21);
            3'd3:    hit = (pos == 5'd9);
            3'd4:    hit = (pos == 5'd25);
            default: hit = (pos == 5'd25) || (pos == 5'd12);
        endcase
        return hit;
    endfunction

    assign key_ready  = (state == ST_IDLE) & ~load;
    assign pos_valid  = (state == ST_HOLD);
    assign key_accept = key_valid & key_ready;

    // All notch tests look at the pre-step positions. The left rotor moves only
    // when the middle rotor moves off its own notch. With the double-step
    // enabled that is every time the middle rotor sits on its notch. As a
    // plain odometer it happens only when the carry from the right arrives
    // there.
    assign right_notch  = on_notch(type_right, rotor_right);
    assign middle_notch = on_notch(type_middle, rotor_middle);
    assign middle_step  = right_notch | (DOUBLE_STEP & middle_notch);
    assign left_step    = middle_step & middle_notch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            rotor_left   <= RESET_POS_5;
            rotor_middle <= RESET_POS_5;
            rotor_right  <= RESET_POS_5;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        rotor_left   <= fold26(load_left);
                        rotor_middle <= fold26(load_middle);
                        rotor_right  <= fold26(load_right);
                    end else if (key_valid) begin
                        state <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    rotor_right <= inc26(rotor_right);
                    if (middle_step) begin
                        rotor_middle <= inc26(rotor_middle);
                    end
                    if (left_step) begin
                        rotor_left <= inc26(rotor_left);
                    end
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (pos_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef KEY_COUNT_EN
    // Counts every accepted keypress. A load leaves it alone; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_count <= 16'd0;
        end else if (key_accept) begin
            key_count <= key_count + 16'd1;
        end
    end
`else
    logic unused_key_accept;
    assign unused_key_accept = key_accept;
`endif

endmodule

// File: tb/tb_rotor_stepper.sv
module tb_rotor_stepper;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [4:0] load_left = '0, load_middle = '0, load_right = '0;
    logic [2:0] type_left = 3'd0, type_middle = 3'd1, type_right = 3'd2;
    logic       key_valid = 1'b0;
    logic       pos_ready = 1'b0;

    logic       kr [2];
    logic       pv [2];
    logic [4:0] rl [2];
    logic [4:0] rm [2];
    logic [4:0] rr [2];
`ifdef KEY_COUNT_EN
    logic [15:0] kc [2];
`endif

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // Instance 0 uses the historical double-step; instance 1 is a plain odometer.
    rotor_stepper #(.RESET_POS(0), .DOUBLE_STEP(1'b1)) dut_ds (
        .clk(clk), .reset(reset), .load(load),
        .load_left(load_left), .load_middle(load_middle), .load_right(load_right),
        .type_left(type_left), .type_middle(type_middle), .type_right(type_right),
        .key_valid(key_valid), .key_ready(kr[0]), .pos_valid(pv[0]), .pos_ready(pos_ready),
        .rotor_left(rl[0]), .rotor_middle(rm[0]), .rotor_right(rr[0])
`ifdef KEY_COUNT_EN
        , .key_count(kc[0])
`endif
    );

    rotor_stepper #(.RESET_POS(0), .DOUBLE_STEP(1'b0)) dut_od (
        .clk(clk), .reset(reset), .load(load),
        .load_left(load_left), .load_middle(load_middle), .load_right(load_right),
        .type_left(type_left), .type_middle(type_middle), .type_right(type_right),
        .key_valid(key_valid), .key_ready(kr[1]), .pos_valid(pv[1]), .pos_ready(pos_ready),
        .rotor_left(rl[1]), .rotor_middle(rm[1]), .rotor_right(rr[1])
`ifdef KEY_COUNT_EN
        , .key_count(kc[1])
`endif
    );

    // ---------------- reference model ----------------
    int notch_a [8] = '{16, 4, 21, 9, 25, 25, 25, 25};
    int notch_b [8] = '{-1, -1, -1, -1, -1, 12, 12, 12};

    int m_l [2] = '{0, 0};
    int m_m [2] = '{0, 0};
    int m_r [2] = '{0, 0};
    int m_ph [2] = '{0, 0};   // 0 waiting for key, 1 stepping, 2 presenting
    int m_cnt [2] = '{0, 0};

    function automatic bit is_notch(input int t, input int p);
        return (p == notch_a[t]) || (p == notch_b[t]);
    endfunction

    function automatic int fold(input int v);
        return (v >= 26) ? v - 26 : v;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_l[k] = 0; m_m[k] = 0; m_r[k] = 0; m_ph[k] = 0; m_cnt[k] = 0;
            end else if (m_ph[k] == 0) begin
                if (load) begin
                    m_l[k] = fold(int'(load_left));
                    m_m[k] = fold(int'(load_middle));
                    m_r[k] = fold(int'(load_right));
                end else if (key_valid) begin
                    m_ph[k] = 1;
                    m_cnt[k] = (m_cnt[k] + 1) % 65536;
                end
            end else if (m_ph[k] == 1) begin
                bit mid_n, mid_turn;
                mid_n    = is_notch(int'(type_middle), m_m[k]);
                mid_turn = is_notch(int'(type_right), m_r[k]) || ((k == 0) && mid_n);
                if (mid_turn && mid_n) m_l[k] = (m_l[k] + 1) % 26;
                if (mid_turn) m_m[k] = (m_m[k] + 1) % 26;
                m_r[k] = (m_r[k] + 1) % 26;
                m_ph[k] = 2;
            end else if (pos_ready) begin
                m_ph[k] = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("cyc%0d_left", k), 32'(rl[k]), 32'(m_l[k]));
                check($sformatf("cyc%0d_middle", k), 32'(rm[k]), 32'(m_m[k]));
                check($sformatf("cyc%0d_right", k), 32'(rr[k]), 32'(m_r[k]));
                check($sformatf("cyc%0d_key_ready", k), 32'(kr[k]), 32'((m_ph[k] == 0) && !load));
                check($sformatf("cyc%0d_pos_valid", k), 32'(pv[k]), 32'(m_ph[k] == 2));
`ifdef KEY_COUNT_EN
                check($sformatf("cyc%0d_key_count", k), 32'(kc[k]), 32'(m_cnt[k]));
`endif
            end
        end
    end

    // ---------------- directed stimulus ----------------
    // Every task starts and ends 1 time unit after a rising edge.
    task automatic do_load(input int l, input int m, input int r);
        load = 1'b1;
        load_left = 5'(l); load_middle = 5'(m); load_right = 5'(r);
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic press();
        int n;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        n = 0;
        while (pv[0] !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (pv[0] !== 1'b1) begin
            total++; bad++;
            $display("FAIL press_timeout got=%0d want=1", pv[0]);
        end
        pos_ready = 1'b1;
        @(posedge clk); #1;
        pos_ready = 1'b0;
    endtask

    function automatic logic [14:0] pos3(input int k);
        return {rl[k], rm[k], rr[k]};
    endfunction

    initial begin
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset state
        check("rst_pos", 32'(pos3(0)), 32'({5'd0, 5'd0, 5'd0}));
        check("rst_key_ready", 32'(kr[0]), 32'd1);
        check("rst_pos_valid", 32'(pv[0]), 32'd0);

        // Double-step sequence A D U with I/II/III
        type_left = 3'd0; type_middle = 3'd1; type_right = 3'd2;
        do_load(0, 3, 20);
        press();
        check("ds_p1", 32'(pos3(0)), 32'({5'd0, 5'd3, 5'd21}));
        check("od_p1", 32'(pos3(1)), 32'({5'd0, 5'd3, 5'd21}));
        press();
        check("ds_p2", 32'(pos3(0)), 32'({5'd0, 5'd4, 5'd22}));
        check("od_p2", 32'(pos3(1)), 32'({5'd0, 5'd4, 5'd22}));
        press();
        check("ds_p3", 32'(pos3(0)), 32'({5'd1, 5'd5, 5'd23}));
        check("od_p3", 32'(pos3(1)), 32'({5'd0, 5'd4, 5'd23}));
        check("model_ds_p3", 32'(m_l[0] * 676 + m_m[0] * 26 + m_r[0]), 32'(1 * 676 + 5 * 26 + 23));
`ifdef KEY_COUNT_EN
        check("count_after_3", 32'(kc[0]), 32'd3);
`endif

        // Right-rotor wrap and the dual notches of VI
        type_middle = 3'd1; type_right = 3'd0;
        do_load(0, 7, 25);
        press();
        check("wrap_I", 32'(pos3(0)), 32'({5'd0, 5'd7, 5'd0}));
        type_right = 3'd5;
        do_load(0, 7, 12);
        press();
        check("vi_notch_m", 32'(pos3(0)), 32'({5'd0, 5'd8, 5'd13}));
        do_load(0, 7, 25);
        press();
        check("vi_notch_z", 32'(pos3(1)), 32'({5'd0, 5'd8, 5'd0}));

        // Load folding of 26..31
        do_load(31, 26, 29);
        check("load_fold", 32'(pos3(0)), 32'({5'd5, 5'd0, 5'd3}));
        do_load(0, 8, 0);

        // Long hold: key_valid and load must both be ignored
        key_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        load = 1'b1; load_left = 5'd1; load_middle = 5'd1; load_right = 5'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_pos", 32'(pos3(0)), 32'({5'd0, 5'd8, 5'd1}));
            check("hold_pv", 32'(pv[0]), 32'd1);
            check("hold_kr", 32'(kr[0]), 32'd0);
        end
        load = 1'b0; key_valid = 1'b0; pos_ready = 1'b1;
        @(posedge clk); #1;
        pos_ready = 1'b0;
        check("release_pv", 32'(pv[0]), 32'd0);
        check("release_kr", 32'(kr[0]), 32'd1);

        // Stray pos_ready in IDLE
        pos_ready = 1'b1;
        @(posedge clk); #1;
        pos_ready = 1'b0;
        check("stray_ready_pos", 32'(pos3(0)), 32'({5'd0, 5'd8, 5'd1}));

        // load wins over key_valid
        load = 1'b1; key_valid = 1'b1;
        load_left = 5'd2; load_middle = 5'd2; load_right = 5'd2;
        #1;
        check("load_key_kr", 32'(kr[0]), 32'd0);
        @(posedge clk); #1;
        load = 1'b0; key_valid = 1'b0;
        @(posedge clk); #1;
        check("load_key_pos", 32'(pos3(0)), 32'({5'd2, 5'd2, 5'd2}));
        check("load_key_pv", 32'(pv[0]), 32'd0);

        // Reset during HOLD
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_pv", 32'(pv[0]), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_hold_pv", 32'(pv[0]), 32'd0);
        check("reset_hold_pos", 32'(pos3(0)), 32'({5'd0, 5'd0, 5'd0}));
`ifdef KEY_COUNT_EN
        check("reset_count", 32'(kc[0]), 32'd0);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
